// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: multi-channel hobby-servo pulse generator.
//
// A prescaler divides clk down to a 1 us tick. A frame counter then runs
// 0..PERIOD_US-1 in ticks. Position commands are scaled into a pulse width
// and held in a per-channel shadow register. All shadows are copied into the
// active registers together at the end of each frame, so a width never
// changes part-way through a pulse.
//
// Optional feature: define SERVO_SLEW_EN to limit how far each active width
// can move per frame (at most SLEW_US). Without it, the copy is direct.
module servo_pwm_multi #(
    parameter int NUM_CH    = 4,
    parameter int POS_W     = 8,
    parameter int TICK_DIV  = 50,
    parameter int PERIOD_US = 20000,
    parameter int MIN_US    = 1000,
    parameter int MAX_US    = 2000,
    parameter int SLEW_US   = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [POS_W-1:0]  pos_data,
    input  logic [3:0]        pos_ch,
    input  logic              pos_valid,
    output logic              pos_ready,
    output logic [NUM_CH-1:0] pwm,
    output logic              frame_start,
    output logic              bad_ch
);

    localparam int US_W  = $clog2(PERIOD_US + 1);
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int PRD_W = POS_W + US_W;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [US_W-1:0]  US_LAST  = US_W'(PERIOD_US - 1);
    localparam logic [US_W-1:0]  MIN_V    = US_W'(MIN_US);
    localparam logic [US_W-1:0]  RANGE_V  = US_W'(MAX_US - MIN_US);
    localparam logic [US_W-1:0]  CENTRE_V =
        US_W'(MIN_US + (((1 << (POS_W - 1)) * (MAX_US - MIN_US)) >> POS_W));

`ifdef SERVO_SLEW_EN
    localparam logic [US_W-1:0]  SLEW_V   =
        US_W'((SLEW_US > PERIOD_US) ? PERIOD_US : SLEW_US);
`endif

    // Reject parameter sets outside the supported range at elaboration.
    if (NUM_CH < 1 || NUM_CH > 16 || POS_W < 4 || POS_W > 12 ||
        TICK_DIV < 2 || MIN_US >= MAX_US || MAX_US >= PERIOD_US ||
        SLEW_US < 1) begin : g_param_err
        $error("servo_pwm_multi: illegal parameter set");
    end

    // Scale a position word into a pulse width in microseconds. The product
    // is kept at full precision before the shift so no bits are lost.
    function automatic logic [US_W-1:0] pos_to_width(input logic [POS_W-1:0] p);
        logic [PRD_W-1:0] prod;
        prod = PRD_W'(p) * PRD_W'(RANGE_V);
        return MIN_V + US_W'(prod >> POS_W);
    endfunction

    logic [PRE_W-1:0]  pre_r;
    logic [US_W-1:0]   us_cnt_r;
    logic [US_W-1:0]   shadow_r     [NUM_CH];
    logic [US_W-1:0]   active_r     [NUM_CH];
    logic [US_W-1:0]   active_nxt_s [NUM_CH];
    logic [NUM_CH-1:0] pwm_r;
    logic              frame_start_r;
    logic              bad_ch_r;
    logic              tick_s;
    logic              copy_s;
    logic              xfer_s;
    logic              ch_ok_s;
    logic [US_W-1:0]   tgt_s;

    assign tick_s  = (pre_r == PRE_LAST);
    assign copy_s  = tick_s && (us_cnt_r == US_LAST);
    // Commands are refused only in the copy cycle, so a shadow can never be
    // written in the same edge that the active registers sample it.
    assign pos_ready = ~rst & ~copy_s;
    assign xfer_s  = pos_valid & pos_ready;
    assign ch_ok_s = ({1'b0, pos_ch} < 5'(NUM_CH));
    assign tgt_s   = pos_to_width(pos_data);

    assign pwm         = pwm_r;
    assign frame_start = frame_start_r;
    assign bad_ch      = bad_ch_r;

    // Prescaler: counts clk cycles to form the 1 us tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_r <= '0;
        end else if (tick_s) begin
            pre_r <= '0;
        end else begin
            pre_r <= pre_r + PRE_W'(1);
        end
    end

    // Frame counter: advances once per tick and wraps at the frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            us_cnt_r <= '0;
        end else if (tick_s) begin
            if (us_cnt_r == US_LAST) begin
                us_cnt_r <= '0;
            end else begin
                us_cnt_r <= us_cnt_r + US_W'(1);
            end
        end else begin
            us_cnt_r <= us_cnt_r;
        end
    end

    // Next active width per channel, computed ahead of the copy cycle.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            active_nxt_s[i] = shadow_r[i];
`ifdef SERVO_SLEW_EN
            if (shadow_r[i] > active_r[i]) begin
                if ((shadow_r[i] - active_r[i]) > SLEW_V) begin
                    active_nxt_s[i] = active_r[i] + SLEW_V;
                end else begin
                    active_nxt_s[i] = shadow_r[i];
                end
            end else begin
                if ((active_r[i] - shadow_r[i]) > SLEW_V) begin
                    active_nxt_s[i] = active_r[i] - SLEW_V;
                end else begin
                    active_nxt_s[i] = shadow_r[i];
                end
            end
`endif
        end
    end

    // Shadow registers: capture accepted commands for in-range channels;
    // a later write in the same frame simply overwrites an earlier one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_r[i] <= CENTRE_V;
            end
        end else if (xfer_s && ch_ok_s) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (pos_ch == 4'(i)) begin
                    shadow_r[i] <= tgt_s;
                end else begin
                    shadow_r[i] <= shadow_r[i];
                end
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_r[i] <= shadow_r[i];
            end
        end
    end

    // Active registers: all channels update together in the copy cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                active_r[i] <= CENTRE_V;
            end
        end else if (copy_s) begin
            for (int i = 0; i < NUM_CH; i++) begin
                active_r[i] <= active_nxt_s[i];
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                active_r[i] <= active_r[i];
            end
        end
    end

    // Pulse outputs: high while the frame position is below the width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_r <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_r[i] <= (us_cnt_r < active_r[i]);
            end
        end
    end

    // Status strobes: frame boundary and out-of-range channel command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start_r <= 1'b0;
            bad_ch_r      <= 1'b0;
        end else begin
            frame_start_r <= copy_s;
            bad_ch_r      <= xfer_s & ~ch_ok_s;
        end
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi with small parameters: 2 clk per us, 100 us
// frame (200 clk), widths 10..20 us, 4-bit positions, 4 channels, slew 2 us.
// Each table row describes one measured frame: up to two commands issued at
// given cycle offsets, and the expected per-channel high time, frame length,
// bad_ch strobe count and number of stalled command cycles.
module tb_servo_pwm_multi;

    localparam int NCH = 4;

    logic       clk;
    logic       rst;
    logic [3:0] pos_data;
    logic [3:0] pos_ch;
    logic       pos_valid;
    logic       pos_ready;
    logic [3:0] pwm;
    logic       frame_start;
    logic       bad_ch;

    servo_pwm_multi #(
        .NUM_CH(NCH), .POS_W(4), .TICK_DIV(2), .PERIOD_US(100),
        .MIN_US(10), .MAX_US(20), .SLEW_US(2)
    ) dut (
        .clk(clk), .rst(rst), .pos_data(pos_data), .pos_ch(pos_ch),
        .pos_valid(pos_valid), .pos_ready(pos_ready), .pwm(pwm),
        .frame_start(frame_start), .bad_ch(bad_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int at1; int c1; int p1;
        int at2; int c2; int p2;
        int w0; int w1; int w2; int w3;
        int bad; int stall;
    } vec_t;

    vec_t vecs[12];
    int   w1_exp[12];
    int   w2_exp[12];
    int   w3_exp[12];

    int   tests;
    int   fails;
    int   meas_w[NCH];
    int   meas_len;
    int   meas_bad;
    int   meas_stall;
    logic wr_busy;
    logic wr_rdy;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int at1, input int c1, input int p1,
                                input int at2, input int c2, input int p2,
                                input int k, input int bad, input int stall);
        vec_t v;
        v.at1 = at1; v.c1 = c1; v.p1 = p1;
        v.at2 = at2; v.c2 = c2; v.p2 = p2;
        v.w0 = 30; v.w1 = w1_exp[k]; v.w2 = w2_exp[k]; v.w3 = w3_exp[k];
        v.bad = bad; v.stall = stall;
        return v;
    endfunction

    // Count pwm high cycles per channel up to and including the next
    // frame_start cycle, issuing up to two commands along the way.
    task automatic measure_frame(input int at1, input int c1, input int p1,
                                 input int at2, input int c2, input int p2);
        int at[2];
        int ch[2];
        int pd[2];
        int nw;
        bit done;
        at[0] = at1; ch[0] = c1; pd[0] = p1;
        at[1] = at2; ch[1] = c2; pd[1] = p2;
        nw = 0;
        done = 1'b0;
        for (int i = 0; i < NCH; i++) meas_w[i] = 0;
        meas_len = 0; meas_bad = 0; meas_stall = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            meas_len++;
            for (int i = 0; i < NCH; i++) meas_w[i] += int'(pwm[i]);
            if (bad_ch) meas_bad++;
            if (wr_busy) begin
                if (wr_rdy) begin
                    pos_valid = 1'b0;
                    wr_busy = 1'b0;
                end else begin
                    wr_rdy = pos_ready;
                    if (!pos_ready) meas_stall++;
                end
            end
            if (!wr_busy && nw < 2 && at[nw] >= 0 && meas_len >= at[nw]) begin
                pos_valid = 1'b1;
                pos_ch    = 4'(ch[nw]);
                pos_data  = 4'(pd[nw]);
                wr_busy   = 1'b1;
                wr_rdy    = pos_ready;
                if (!pos_ready) meas_stall++;
                nw++;
            end
            if (frame_start) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) meas_len = -1;
    endtask

    initial begin
        tests = 0; fails = 0;
        wr_busy = 1'b0; wr_rdy = 1'b0;
        rst = 1'b1; pos_valid = 1'b0; pos_ch = 4'd0; pos_data = 4'd0;

`ifdef SERVO_SLEW_EN
        w1_exp = '{30, 30, 34, 38, 34, 30, 26, 22, 20, 20, 20, 20};
        w2_exp = '{30, 30, 30, 30, 30, 30, 30, 30, 30, 34, 38, 38};
        w3_exp = '{30, 30, 30, 30, 30, 30, 30, 30, 30, 30, 30, 34};
`else
        w1_exp = '{30, 30, 38, 38, 20, 20, 20, 20, 20, 20, 20, 20};
        w2_exp = '{30, 30, 30, 30, 30, 30, 30, 30, 30, 38, 38, 38};
        w3_exp = '{30, 30, 30, 30, 30, 30, 30, 30, 30, 30, 30, 38};
`endif
        vecs[0]  = mk(-1, 0, 0,  -1, 0, 0,   0, 0, 0); // centre after reset
        vecs[1]  = mk(50, 1, 15, -1, 0, 0,   1, 0, 0); // mid-frame write held off
        vecs[2]  = mk(-1, 0, 0,  -1, 0, 0,   2, 0, 0);
        vecs[3]  = mk(10, 1, 0,  -1, 0, 0,   3, 0, 0); // write during pulse
        vecs[4]  = mk(-1, 0, 0,  -1, 0, 0,   4, 0, 0);
        vecs[5]  = mk(60, 7, 3,  -1, 0, 0,   5, 1, 0); // out-of-range channel
        vecs[6]  = mk(-1, 0, 0,  -1, 0, 0,   6, 0, 0);
        vecs[7]  = mk(199, 2, 15, -1, 0, 0,  7, 0, 1); // valid across copy cycle
        vecs[8]  = mk(-1, 0, 0,  -1, 0, 0,   8, 0, 0);
        vecs[9]  = mk(-1, 0, 0,  -1, 0, 0,   9, 0, 0);
        vecs[10] = mk(40, 3, 0,  45, 3, 15, 10, 0, 0); // last write wins
        vecs[11] = mk(-1, 0, 0,  -1, 0, 0,  11, 0, 0);

        repeat (3) @(negedge clk);
        check("rst_pwm",         int'(pwm),         0);
        check("rst_frame_start", int'(frame_start), 0);
        check("rst_bad_ch",      int'(bad_ch),      0);
        check("rst_pos_ready",   int'(pos_ready),   0);
        rst = 1'b0;

        for (int k = 0; k < 12; k++) begin
            measure_frame(vecs[k].at1, vecs[k].c1, vecs[k].p1,
                          vecs[k].at2, vecs[k].c2, vecs[k].p2);
            check($sformatf("f%0d_w0", k), meas_w[0], vecs[k].w0);
            check($sformatf("f%0d_w1", k), meas_w[1], vecs[k].w1);
            check($sformatf("f%0d_w2", k), meas_w[2], vecs[k].w2);
            check($sformatf("f%0d_w3", k), meas_w[3], vecs[k].w3);
            check($sformatf("f%0d_len", k), meas_len, 200);
            check($sformatf("f%0d_bad", k), meas_bad, vecs[k].bad);
            check($sformatf("f%0d_stall", k), meas_stall, vecs[k].stall);
        end

        // Reset in the middle of a pulse: outputs drop without waiting for
        // a clock edge, then the block restarts at centre width.
        repeat (10) @(negedge clk);
        check("pre_rst_pwm", int'(pwm), 15);
        rst = 1'b1;
        #1;
        check("async_rst_pwm",       int'(pwm),       0);
        check("async_rst_pos_ready", int'(pos_ready), 0);
        repeat (3) @(negedge clk);
        check("hold_rst_frame_start", int'(frame_start), 0);
        rst = 1'b0;
        measure_frame(-1, 0, 0, -1, 0, 0);
        check("restart_w0",  meas_w[0], 30);
        check("restart_w1",  meas_w[1], 30);
        check("restart_w2",  meas_w[2], 30);
        check("restart_w3",  meas_w[3], 30);
        check("restart_len", meas_len,  200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
